i2c_controller: RTL
===================

I2C_CONTROLLER -- requirements
Module: i2c_controller

Interface
REQ-001 Parameter CLK_DIV, default 125, clk cycles per SCL quarter-period; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL change on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command request; accepted when cmd_valid && cmd_ready on posedge clk.
REQ-005 cmd_ready  output  1  high only in IDLE.
REQ-006 cmd_addr  input  7  target address, captured on accept.
REQ-007 cmd_rw  input  1  0 = write one byte, 1 = read one byte; captured on accept.
REQ-008 cmd_wdata  input  8  write byte, captured on accept.
REQ-009 rdata  output  8  read byte; valid when done pulses after a read.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 nack_err  output  1  valid with done; 1 = target NACKed address or write data.
REQ-012 busy  output  1  high from accept until done.
REQ-013 scl, sda  inout  1 each  open-drain: drive 0 or release to 'z, never drive 1.

Function
REQ-014 Quarter tick every CLK_DIV cycles while busy; counter cleared on accept; no ticks in IDLE.
REQ-015 Bit period = 4 quarters: Q0 SCL low, SDA updated; Q1,Q2 SCL released; SDA sampled at end of Q2; Q3 SCL low.
REQ-016 States: IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK, STOP.
REQ-017 IDLE -> START on accept; START: SDA pulled low while SCL released (2 quarters), then SCL low (2 quarters).
REQ-018 ADDR: 8 bits {cmd_addr, cmd_rw}, MSB first, bit counter 7 down to 0, then ADDR_ACK.
REQ-019 ADDR_ACK: SDA released; sampled 0 -> WDATA (rw=0) or RDATA (rw=1); sampled 1 -> nack_err set, -> STOP.
REQ-020 WDATA: 8 bits MSB first -> WDATA_ACK; sampled 1 sets nack_err; -> STOP either way.
REQ-021 RDATA: SDA released, 8 samples shifted in MSB first -> RDATA_NACK; controller releases SDA (NACK) for that bit -> STOP.
REQ-022 STOP: SDA low with SCL low (Q0), SCL released (Q1), SDA released while SCL high (Q2-Q3); then done=1 for one cycle, -> IDLE.
REQ-023 Latency accept-to-done: 80*CLK_DIV+1 cycles for completed read/write; 44*CLK_DIV+1 cycles on address NACK.
REQ-024 cmd_valid while busy SHALL be ignored (cmd_ready=0); no queueing.
REQ-025 rdata SHALL update only at RDATA_NACK entry and hold otherwise; nack_err cleared on accept.
REQ-026 No clock stretching and no arbitration: SCL is not sampled.
REQ-027 Same-cycle done and cmd_valid: command not accepted that cycle (cmd_ready rises the cycle after done).

Reset
REQ-028 rst SHALL immediately release scl and sda, force IDLE, clear tick/bit counters.
REQ-029 Reset values: cmd_ready=1 after release, busy=0, done=0, nack_err=0, rdata=8'h00.
REQ-030 rst mid-transaction: bus released without STOP, no done pulse; next command starts fresh.

Structure
REQ-031 Package i2c_pkg SHALL hold the state enum, 2-bit quarter-phase type and I2C_READ/I2C_WRITE constants.
REQ-032 One sub-module, i2c_clk_div (parameter CLK_DIV, enable in, tick out), generates quarter ticks.

Verification (CLK_DIV=4, behavioural target at 7'h42 with pull-ups)
REQ-033 Write 0xA5 to 0x42 -> SDA bits 0x84 then 0xA5, both ACKed; done at 321 cycles after accept, nack_err=0.
REQ-034 Read from 0x42, target sends 0x3C -> SDA 0x85, rdata=0x3C, controller NACKs 9th bit, STOP seen, nack_err=0.
REQ-035 Write to 0x17 (no target) -> address NACK, STOP, done at 177 cycles, nack_err=1.
REQ-036 Target NACKs write data -> nack_err=1, STOP still issued, done pulses once.
REQ-037 rst asserted mid-ADDR -> scl/sda 'z same cycle, busy=0, no done; following write to 0x42 completes normally.
REQ-038 cmd_valid held through a transaction -> exactly one accept per done; START only when SCL and SDA both released.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the single-byte I2C
//                controller: controller state encoding, the 2-bit quarter
//                phase of an SCL bit period, and the R/W bit values.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    // Controller states. Width is fixed so the encoding is stable across tools.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START      = 4'd1,
        ST_ADDR       = 4'd2,
        ST_ADDR_ACK   = 4'd3,
        ST_WDATA      = 4'd4,
        ST_WDATA_ACK  = 4'd5,
        ST_RDATA      = 4'd6,
        ST_RDATA_NACK = 4'd7,
        ST_STOP       = 4'd8
    } i2c_state_t;

    // Quarter phase within one SCL bit period.
    typedef logic [1:0] quarter_t;

    localparam quarter_t c_Q0 = 2'd0;   // SCL low, SDA may change
    localparam quarter_t c_Q1 = 2'd1;   // SCL released
    localparam quarter_t c_Q2 = 2'd2;   // SCL released, SDA sampled at end
    localparam quarter_t c_Q3 = 2'd3;   // SCL low

    // Value of the R/W bit appended to the 7-bit address.
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_clk_div
//  Description : Quarter-period tick generator. While enabled, emits a
//                one-cycle registered tick every CLK_DIV clk cycles. While
//                disabled the counter is held at zero, so the first tick
//                after enable rising always lands a full CLK_DIV later.
//  Ports       : clk    - system clock
//                rst    - asynchronous active-high reset
//                enable - count while high, hold cleared while low
//                tick   - one-cycle pulse per elapsed quarter period
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_clk_div #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int              c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!enable) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == c_LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule : i2c_clk_div
`default_nettype wire

// File: rtl/i2c_controller.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_controller
//  Description : Single-byte I2C master. Accepts one command (7-bit address,
//                R/W, write byte), runs START, address, ACK, one data byte,
//                ACK/NACK and STOP on an open-drain bus, then pulses done.
//                No clock stretching, no arbitration: SCL is never sampled.
//  Ports       : clk, rst              - clock, async active-high reset
//                cmd_valid/cmd_ready   - command handshake (ready only in IDLE)
//                cmd_addr/rw/wdata     - command fields, captured on accept
//                rdata                 - read byte, valid with done after read
//                done                  - one-cycle end-of-transaction pulse
//                nack_err              - address or write data was NACKed
//                busy                  - transaction in progress
//                scl, sda              - open-drain bus lines (0 or 'z only)
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_controller
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       nack_err,
    output logic       busy,
    inout  wire        scl,
    inout  wire        sda
);

    i2c_state_t r_state;
    i2c_state_t w_state_next;

    quarter_t   r_phase;
    logic [2:0] r_bit;
    logic [7:0] r_addr_byte;
    logic [7:0] r_wdata;
    logic [7:0] r_rx;
    logic [7:0] r_rdata;
    logic       r_nack;
    logic       r_ack;
    logic       r_done;

    logic       w_tick;
    logic       w_accept;
    logic       w_bit_end;
    logic       w_bit_scl_low;
    logic       w_is_read;
    logic       w_scl_low;
    logic       w_sda_low;
    logic       w_done_set;
    logic       w_sda_in;

    // ------------------------------------------------------------------
    // Quarter tick generation: only runs while a transaction is active.
    // ------------------------------------------------------------------
    i2c_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .enable (busy),
        .tick   (w_tick)
    );

    // Ready is withheld during the done cycle so a waiting command is taken
    // one cycle after done, never on the same edge.
    assign cmd_ready     = (r_state == ST_IDLE) && !r_done;
    assign busy          = (r_state != ST_IDLE);
    assign w_accept      = cmd_valid && cmd_ready;
    assign w_bit_end     = w_tick && (r_phase == c_Q3);
    assign w_bit_scl_low = (r_phase == c_Q0) || (r_phase == c_Q3);
    assign w_is_read     = (r_addr_byte[0] == I2C_READ);
    assign w_sda_in      = sda;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Every state lasts whole bit periods, so all
    // transitions happen on the tick that ends Q3.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_bit_end) w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (w_bit_end && (r_bit == 3'd0)) w_state_next = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
                if (w_bit_end) begin
                    if (r_ack)          w_state_next = ST_STOP;
                    else if (w_is_read) w_state_next = ST_RDATA;
                    else                w_state_next = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (w_bit_end && (r_bit == 3'd0)) w_state_next = ST_WDATA_ACK;
            end
            ST_WDATA_ACK: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_RDATA: begin
                if (w_bit_end && (r_bit == 3'd0)) w_state_next = ST_RDATA_NACK;
            end
            ST_RDATA_NACK: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (bus drive requests and the done strobe).
    // ------------------------------------------------------------------
    always_comb begin
        w_scl_low  = 1'b0;
        w_sda_low  = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            ST_START: begin
                // SDA falls first with SCL high, then SCL is pulled low.
                w_sda_low = 1'b1;
                w_scl_low = (r_phase == c_Q2) || (r_phase == c_Q3);
            end
            ST_ADDR: begin
                w_scl_low = w_bit_scl_low;
                w_sda_low = !r_addr_byte[r_bit];
            end
            ST_WDATA: begin
                w_scl_low = w_bit_scl_low;
                w_sda_low = !r_wdata[r_bit];
            end
            ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA, ST_RDATA_NACK: begin
                // SDA stays released: target drives ACK/data, and the
                // released SDA in RDATA_NACK is the controller's NACK.
                w_scl_low = w_bit_scl_low;
            end
            ST_STOP: begin
                case (r_phase)
                    c_Q0: begin
                        w_scl_low = 1'b1;
                        w_sda_low = 1'b1;
                    end
                    c_Q1: begin
                        w_sda_low = 1'b1;
                    end
                    default: begin
                        // SDA rising while SCL is high forms the STOP.
                    end
                endcase
                w_done_set = w_bit_end;
            end
            default: begin
            end
        endcase
    end

    // Open drain: pull low or release, never drive high.
    assign scl = w_scl_low ? 1'b0 : 1'bz;
    assign sda = w_sda_low ? 1'b0 : 1'bz;

    // ------------------------------------------------------------------
    // Datapath: quarter phase, bit counter, capture and sampling.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= c_Q0;
            r_bit       <= 3'd0;
            r_addr_byte <= 8'h00;
            r_wdata     <= 8'h00;
            r_rx        <= 8'h00;
            r_rdata     <= 8'h00;
            r_nack      <= 1'b0;
            r_ack       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_accept) begin
                r_phase     <= c_Q0;
                r_bit       <= 3'd7;
                r_addr_byte <= {cmd_addr, cmd_rw};
                r_wdata     <= cmd_wdata;
                r_rx        <= 8'h00;
                r_nack      <= 1'b0;
                r_ack       <= 1'b0;
            end else if (w_tick) begin
                r_phase <= r_phase + 2'd1;

                // End of Q2: SCL has been high for two quarters.
                if (r_phase == c_Q2) begin
                    case (r_state)
                        ST_ADDR_ACK, ST_WDATA_ACK: begin
                            r_ack <= w_sda_in;
                            if (w_sda_in) r_nack <= 1'b1;
                        end
                        ST_RDATA: begin
                            r_rx <= {r_rx[6:0], w_sda_in};
                        end
                        default: begin
                        end
                    endcase
                end

                // Bit counter wraps 0 -> 7, so it is ready for the next byte.
                if ((r_phase == c_Q3) &&
                    ((r_state == ST_ADDR) || (r_state == ST_WDATA) ||
                     (r_state == ST_RDATA))) begin
                    r_bit <= r_bit - 3'd1;
                end

                // rdata changes only when entering RDATA_NACK.
                if ((r_state == ST_RDATA) && (r_phase == c_Q3) &&
                    (r_bit == 3'd0)) begin
                    r_rdata <= r_rx;
                end
            end
        end
    end

    assign rdata    = r_rdata;
    assign nack_err = r_nack;
    assign done     = r_done;

endmodule : i2c_controller
`default_nettype wire
